// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C initiator.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_NACK,
    STOP
  } i2c_state_t;

  localparam logic        I2C_WRITE = 1'b0;
  localparam logic        I2C_READ  = 1'b1;
  localparam int unsigned I2C_BITS  = 8;

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-period timebase: CLK prescaler, quarter index within a bit slot and
// bit index within an 8-bit field. Everything is held at zero while idle.
module i2c_qtick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_run,
  input  logic       i_bit_en,
  output logic       o_qtick,
  output logic [1:0] o_quarter,
  output logic [2:0] o_bit
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_quarter;
  logic [2:0]    r_bit;

  assign o_qtick   = i_run && (r_cnt == LAST);
  assign o_quarter = r_quarter;
  assign o_bit     = r_bit;

  // Prescaler, quarter and bit counters; bit index only advances inside a data field.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt     <= '0;
      r_quarter <= '0;
      r_bit     <= '0;
    end else if (!i_run) begin
      r_cnt     <= '0;
      r_quarter <= '0;
      r_bit     <= '0;
    end else if (o_qtick) begin
      r_cnt     <= '0;
      r_quarter <= r_quarter + 2'd1;
      if ((r_quarter == 2'd3) && i_bit_en)
        r_bit <= r_bit + 3'd1;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C initiator: START, {addr,rw}, ACK, one data byte, STOP.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start_req,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] wr_data,
  output logic       SCL,
  inout  wire        SDA,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rd_data
);

  i2c_state_t r_state, w_next;

  logic       w_qtick;
  logic [1:0] w_quarter;
  logic [2:0] w_bit;
  logic       w_run;
  logic       w_field;
  logic       w_sample;
  logic       w_slot_end;
  logic       w_last_bit;
  logic       w_accept;
  logic       w_sda_in;
  logic       w_scl;
  logic       w_sda_low;

  logic [7:0] r_shift;
  logic [7:0] r_wdata;
  logic       r_rw;
  logic       r_ack_err;
  logic       r_done;
  logic [7:0] r_rd_data;

  assign w_run      = (r_state != IDLE);
  assign w_field    = (r_state == ADDR) || (r_state == WRITE) || (r_state == READ);
  assign w_sample   = w_qtick && (w_quarter == 2'd2);
  assign w_slot_end = w_qtick && (w_quarter == 2'd3);
  assign w_last_bit = (w_bit == 3'(I2C_BITS - 1));
  assign w_accept   = (r_state == IDLE) && start_req;
  assign w_sda_in   = SDA;

  i2c_qtick_gen #(.CLK_DIV(CLK_DIV)) u_qtick (
    .CLK       (CLK),
    .RST       (RST),
    .i_run     (w_run),
    .i_bit_en  (w_field),
    .o_qtick   (w_qtick),
    .o_quarter (w_quarter),
    .o_bit     (w_bit)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state: every transition except accept happens at the end of a bit slot.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (start_req) w_next = START;
      START:     if (w_slot_end) w_next = ADDR;
      ADDR:      if (w_slot_end && w_last_bit) w_next = ADDR_ACK;
      ADDR_ACK:  if (w_slot_end)
                   w_next = r_ack_err ? STOP : ((r_rw == I2C_READ) ? READ : WRITE);
      WRITE:     if (w_slot_end && w_last_bit) w_next = WRITE_ACK;
      WRITE_ACK: if (w_slot_end) w_next = STOP;
      READ:      if (w_slot_end && w_last_bit) w_next = READ_NACK;
      READ_NACK: if (w_slot_end) w_next = STOP;
      STOP:      if (w_slot_end) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // Bus drive decode: SCL low in q0-q1 of every clocked slot, SDA from state/shift register.
  always_comb begin
    w_scl     = 1'b1;
    w_sda_low = 1'b0;
    case (r_state)
      IDLE:  w_scl = 1'b1;
      START: w_sda_low = w_quarter[1];
      ADDR, WRITE: begin
        w_scl     = w_quarter[1];
        w_sda_low = ~r_shift[7];
      end
      STOP: begin
        w_scl     = w_quarter[1];
        w_sda_low = (w_quarter != 2'd3);
      end
      default: w_scl = w_quarter[1];
    endcase
  end

  // Datapath: request capture, shift register, ACK error flag, read result, done pulse.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_shift   <= '0;
      r_wdata   <= '0;
      r_rw      <= I2C_WRITE;
      r_ack_err <= 1'b0;
      r_done    <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_done <= (r_state == STOP) && w_slot_end;
      if (w_accept) begin
        r_shift   <= {slave_addr, rw};
        r_wdata   <= wr_data;
        r_rw      <= rw;
        r_ack_err <= 1'b0;
      end else begin
        case (r_state)
          ADDR, WRITE: if (w_slot_end) r_shift <= {r_shift[6:0], 1'b0};
          ADDR_ACK: begin
            if (w_sample && w_sda_in) r_ack_err <= 1'b1;
            if (w_slot_end && (r_rw == I2C_WRITE)) r_shift <= r_wdata;
          end
          WRITE_ACK: if (w_sample && w_sda_in) r_ack_err <= 1'b1;
          READ:      if (w_sample) r_shift <= {r_shift[6:0], w_sda_in};
          STOP:      if (w_slot_end && (r_rw == I2C_READ) && !r_ack_err) r_rd_data <= r_shift;
          default:   ;
        endcase
      end
    end
  end

  assign SDA     = w_sda_low ? 1'b0 : 1'bz;
  assign SCL     = w_scl;
  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign ack_err = r_ack_err;
  assign rd_data = r_rd_data;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: bus-level responder, slot-arithmetic reference model,
// per-cycle comparison and a START/STOP protocol monitor.
module tb_i2c_master_ctrl;

  localparam int D  = 2;
  localparam int QD = 4 * D;
  localparam logic [6:0] RESP_ADDR = 7'h50;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start_req = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] slave_addr = '0;
  logic [7:0] wr_data = '0;
  logic       SCL;
  wire        SDA;
  logic       busy, done, ack_err;
  logic [7:0] rd_data;

  int n_chk = 0;
  int n_err = 0;

  i2c_master_ctrl #(.CLK_DIV(D)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start_req  (start_req),
    .rw         (rw),
    .slave_addr (slave_addr),
    .wr_data    (wr_data),
    .SCL        (SCL),
    .SDA        (SDA),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .rd_data    (rd_data)
  );

  always #5 CLK = ~CLK;

  pullup (SDA);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- responder (bus-level, reacts to SCL/SDA edges) ----------------
  logic       resp_present = 1'b1;
  logic       resp_wack = 1'b1;
  logic [7:0] resp_rdata = '0;
  logic       r_low = 1'b0;
  logic       r_active = 1'b0;
  logic       r_sel = 1'b0;
  int         bitn = 0;
  logic [7:0] rx_addr = '0;
  logic [7:0] rx_data = '0;
  logic       rx_nack = 1'b0;
  logic       rp_scl = 1'b1;
  logic       rp_sda = 1'b1;

  assign SDA = r_low ? 1'b0 : 1'bz;

  always @(posedge CLK) begin
    logic s_scl, s_sda;
    #1;
    s_scl = SCL;
    s_sda = SDA;
    if (rp_scl && s_scl && rp_sda && !s_sda) begin
      r_active = 1'b1; r_sel = 1'b0; bitn = 0; r_low = 1'b0;
    end else if (rp_scl && s_scl && !rp_sda && s_sda) begin
      r_active = 1'b0; r_low = 1'b0;
    end else if (r_active && !rp_scl && s_scl) begin
      if (bitn < 8) rx_addr = {rx_addr[6:0], s_sda};
      else if (bitn >= 9 && bitn <= 16) rx_data = {rx_data[6:0], s_sda};
      else if (bitn == 17) rx_nack = s_sda;
      bitn++;
    end else if (r_active && rp_scl && !s_scl) begin
      r_low = 1'b0;
      if (bitn == 8) begin
        r_sel = resp_present && (rx_addr[7:1] == RESP_ADDR);
        r_low = r_sel;
      end else if (r_sel && rx_addr[0] && bitn >= 9 && bitn <= 16) begin
        r_low = !resp_rdata[16 - bitn];
      end else if (r_sel && !rx_addr[0] && bitn == 17) begin
        r_low = resp_wack;
      end
    end
    rp_scl = s_scl;
    rp_sda = s_sda;
  end

  // ---------------- reference model: transaction as a sequence of slots ----------------
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic       m_err = 1'b0;
  logic       m_aack = 1'b0;
  logic [7:0] m_rd = '0;
  logic [7:0] m_abyte = '0;
  logic [7:0] m_wdata = '0;
  int         m_k = 0;
  int         m_nslots = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_rd = '0; m_k = 0;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start_req) begin
          m_busy   = 1'b1;
          m_k      = 0;
          m_abyte  = {slave_addr, rw};
          m_wdata  = wr_data;
          m_err    = 1'b0;
          m_aack   = resp_present && (slave_addr == RESP_ADDR);
          m_nslots = m_aack ? 20 : 11;
        end
      end else begin
        m_k++;
        if (m_k == m_nslots * QD) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          m_err  = !m_aack || (!m_abyte[0] && !resp_wack);
          if (m_aack && m_abyte[0]) m_rd = resp_rdata;
        end
      end
    end
  end

  // ---------------- per-cycle compare and protocol monitor ----------------
  logic proto_en = 1'b1;
  int   n_start = 0;
  int   n_stop = 0;
  logic p_scl = 1'b1;
  logic p_sda = 1'b1;

  always @(negedge CLK) begin
    logic e_scl, e_low;
    int s, q;
    if (m_busy) begin
      s = m_k / QD;
      q = (m_k % QD) / D;
      e_scl = (s == 0) || (q >= 2);
      if (s == 0)                                  e_low = (q >= 2);
      else if (s == m_nslots - 1)                  e_low = (q < 3);
      else if (s >= 1 && s <= 8)                   e_low = !m_abyte[8 - s];
      else if (s >= 10 && s <= 17 && !m_abyte[0])  e_low = !m_wdata[17 - s];
      else                                         e_low = 1'b0;
    end else begin
      e_scl = 1'b1;
      e_low = 1'b0;
    end
    chk("scl", SCL, e_scl);
    chk("sda", SDA, !(e_low || r_low));
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("rd_data", rd_data, m_rd);
    if (!m_busy || m_k < 9 * QD) chk("ack_err", ack_err, m_err);
    if (proto_en && p_scl && SCL && (SDA !== p_sda)) begin
      if (SDA === 1'b0) n_start++;
      else              n_stop++;
    end
    if (m_done && proto_en) begin
      chk("start_count", n_start, 1);
      chk("stop_count", n_stop, 1);
      n_start = 0;
      n_stop  = 0;
    end
    p_scl = SCL;
    p_sda = SDA;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] d, input logic hold);
    @(negedge CLK);
    slave_addr = a; rw = r; wr_data = d; start_req = 1'b1;
    @(negedge CLK);
    if (!hold) start_req = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int lat;
    lat = 0;
    while (done !== 1'b1 && lat < 2000) begin
      @(negedge CLK);
      lat++;
    end
    chk(nm, lat, exp_lat);
  endtask

  initial begin
    int n;
    logic [6:0] a;
    logic       r;
    logic [7:0] d;

    repeat (3) @(negedge CLK);
    chk("rst_scl", SCL, 1'b1);
    chk("rst_sda", SDA, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_ack_err", ack_err, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    #2 RST = 1'b0;

    // write 0x50 <- 0xA5, acked
    issue(7'h50, 1'b0, 8'hA5, 1'b0);
    wait_done("wr_latency", 160);
    chk("wr_addr_byte", rx_addr, 8'hA0);
    chk("wr_data_byte", rx_data, 8'hA5);
    chk("wr_ack_err", ack_err, 1'b0);

    // read 0x50 -> 0x3C
    resp_rdata = 8'h3C;
    issue(7'h50, 1'b1, 8'h00, 1'b0);
    wait_done("rd_latency", 160);
    chk("rd_addr_byte", rx_addr, 8'hA1);
    chk("rd_result", rd_data, 8'h3C);
    chk("rd_master_nack", rx_nack, 1'b1);

    // no responder: address NACK
    resp_present = 1'b0;
    issue(7'h50, 1'b1, 8'h00, 1'b0);
    wait_done("nack_latency", 88);
    chk("nack_ack_err", ack_err, 1'b1);
    chk("nack_rd_kept", rd_data, 8'h3C);
    resp_present = 1'b1;

    // reset during WRITE bit 3 (slot 13, q0)
    issue(7'h50, 1'b0, 8'hC3, 1'b0);
    n = 0;
    while (!(m_busy && m_k == 13 * QD + 1) && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("reach_write_bit3", (n < 1000), 1'b1);
    proto_en = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("midrst_scl", SCL, 1'b1);
    chk("midrst_sda", SDA, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rd_data", rd_data, 8'h00);
    @(negedge CLK);
    #2 RST = 1'b0;
    repeat (2) @(negedge CLK);
    n_start = 0; n_stop = 0; proto_en = 1'b1;
    issue(7'h50, 1'b0, 8'h5A, 1'b0);
    wait_done("post_rst_latency", 160);
    chk("post_rst_data_byte", rx_data, 8'h5A);
    chk("post_rst_ack_err", ack_err, 1'b0);

    // start_req held high: one transaction, re-accept on the edge after done
    issue(7'h50, 1'b0, 8'h96, 1'b1);
    wait_done("held_latency", 160);
    @(negedge CLK);
    chk("held_reaccept", busy, 1'b1);
    start_req = 1'b0;
    wait_done("held_second_latency", 160);

    // randomized transactions
    for (int i = 0; i < 8; i++) begin
      a = ($urandom_range(0, 1) == 0) ? RESP_ADDR : 7'($urandom_range(0, 127));
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      resp_rdata = 8'($urandom);
      resp_wack  = 1'($urandom_range(0, 3) != 0);
      issue(a, r, d, 1'b0);
      wait_done("rand_latency", ((a == RESP_ADDR) ? 20 : 11) * QD);
    end

    repeat (4) @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
